mem_ctr_line: RTL and testbench

- Parametrised successor to the bus-2 memory controller: a line-granular backing store behind the cache.
- Executes multi-beat READ_LINE and WRITE_LINE transactions with a configurable access latency and busy back-pressure.
- Reports out-of-range line addresses with an error response.
- Uses split in/out bus-2 signals (no inout), so the block is synthesizable.

---
 rtl/mem_ctr_line.sv | 158 +++++++++++++++
 tb/tb_mem_ctr_line.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctr_line.sv
// Line-granular backing store behind the cache: multi-beat line reads and
// writes over split bus-2 signals with fixed access latency and error replies.
module mem_ctr_line #(
   parameter int LINE_BYTES = 16,
   parameter int DATA_W     = 16,
   parameter int MEM_LINES  = 1024,
   parameter int ADDR_W     = 10,
   parameter int LATENCY    = 100
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic [1:0]        C2_IN,
   input  logic [ADDR_W-1:0] A2_IN,
   input  logic [DATA_W-1:0] D2_IN,
   output logic [1:0]        C2_OUT,
   output logic [DATA_W-1:0] D2_OUT,
   output logic              BUSY
);

   localparam int BEATS = LINE_BYTES * 8 / DATA_W;
   localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int LW    = $clog2(LATENCY + 1);
   localparam int DEPTH = MEM_LINES * BEATS;
   localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_WR_RX, S_WAIT, S_RD_TX, S_WR_RESP
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [ADDR_W-1:0] r_addr;
   logic              r_err;
   logic              r_wr;
   logic [BW-1:0]     r_beat;
   logic [LW-1:0]     r_lat;
   logic [1:0]        r_c2;
   logic [DATA_W-1:0] r_d2;
   logic [DATA_W-1:0] r_mem [DEPTH];

   logic              w_cmd_rd;
   logic              w_cmd_wr;
   logic              w_a_ok;
   logic              w_last;
   logic              w_lat_done;
   logic              w_we;
   logic [IW-1:0]     w_wr_idx;
   logic [IW-1:0]     w_rd_idx;
   logic [1:0]        w_rsp;
   logic [1:0]        w_c2_nxt;
   logic [DATA_W-1:0] w_d2_nxt;

   assign w_cmd_rd   = (C2_IN == 2'd2);
   assign w_cmd_wr   = (C2_IN == 2'd3);
   assign w_a_ok     = (int'(A2_IN) < MEM_LINES);
   assign w_last     = (r_beat == BW'(BEATS - 1));
   assign w_lat_done = (r_lat == LW'(LATENCY));
   assign w_rsp      = r_err ? 2'd2 : 2'd1;

   // Beat 0 of a write lands on the command edge, so it indexes from A2_IN.
   assign w_wr_idx = (r_state == S_IDLE)
                   ? IW'(int'(A2_IN) * BEATS)
                   : IW'(int'(r_addr) * BEATS + int'(r_beat));
   assign w_rd_idx = (r_state == S_RD_TX)
                   ? IW'(int'(r_addr) * BEATS + int'(r_beat) + 1)
                   : IW'(int'(r_addr) * BEATS);
   assign w_we = ((r_state == S_IDLE) && w_cmd_wr && w_a_ok)
              || ((r_state == S_WR_RX) && !r_err);

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (w_cmd_wr)      w_next = (BEATS == 1) ? S_WAIT : S_WR_RX;
            else if (w_cmd_rd) w_next = S_WAIT;
         end
         S_WR_RX:   if (w_last) w_next = S_WAIT;
         S_WAIT:    if (w_lat_done) w_next = r_wr ? S_WR_RESP : S_RD_TX;
         S_RD_TX:   if (w_last) w_next = S_IDLE;
         S_WR_RESP: w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_c2_nxt = 2'd0;
      w_d2_nxt = '0;
      unique case (r_state)
         S_WAIT: begin
            if (w_lat_done) begin
               w_c2_nxt = w_rsp;
               if (!r_wr && !r_err) w_d2_nxt = r_mem[w_rd_idx];
            end
         end
         S_RD_TX: begin
            if (!w_last) begin
               w_c2_nxt = w_rsp;
               if (!r_err) w_d2_nxt = r_mem[w_rd_idx];
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_addr <= '0;
         r_err  <= 1'b0;
         r_wr   <= 1'b0;
         r_beat <= '0;
         r_lat  <= '0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               r_beat <= BW'(1);
               r_lat  <= '0;
               if (w_cmd_wr || w_cmd_rd) begin
                  r_addr <= A2_IN;
                  r_err  <= !w_a_ok;
                  r_wr   <= w_cmd_wr;
               end
            end
            S_WR_RX: r_beat <= w_last ? '0 : r_beat + 1'b1;
            S_WAIT: begin
               r_lat  <= r_lat + 1'b1;
               r_beat <= '0;
            end
            S_RD_TX: r_beat <= r_beat + 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_c2 <= 2'd0;
         r_d2 <= '0;
      end else begin
         r_c2 <= w_c2_nxt;
         r_d2 <= w_d2_nxt;
      end
   end

   // Storage is deliberately outside reset: contents survive RESET.
   always_ff @(posedge CLK) begin
      if (w_we) r_mem[w_wr_idx] <= D2_IN;
   end

   assign C2_OUT = r_c2;
   assign D2_OUT = r_d2;
   assign BUSY   = (r_state != S_IDLE);

endmodule

// File: tb/tb_mem_ctr_line.sv
// Bench for mem_ctr_line: edge-indexed transaction model plus literal pins,
// directed scenarios and a randomized command stream.
module tb_mem_ctr_line;

   localparam int LAT   = 4;
   localparam int BEATS = 8;

   logic        CLK;
   logic        RESET;
   logic [1:0]  C2_IN;
   logic [3:0]  A2_IN;
   logic [15:0] D2_IN;
   logic [1:0]  C2_OUT;
   logic [15:0] D2_OUT;
   logic        BUSY;

   mem_ctr_line #(
      .LINE_BYTES(16), .DATA_W(16), .MEM_LINES(8),
      .ADDR_W(4), .LATENCY(LAT)
   ) dut (
      .CLK(CLK), .RESET(RESET),
      .C2_IN(C2_IN), .A2_IN(A2_IN), .D2_IN(D2_IN),
      .C2_OUT(C2_OUT), .D2_OUT(D2_OUT), .BUSY(BUSY)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: edge-numbered expectations, no notion of the DUT's states.
   logic [15:0] mm [8][8];
   logic [1:0]  exp_c2 [int];
   logic [15:0] exp_d2 [int];
   int cyc      = 0;
   int acc_edge = -1;
   int ret_edge = -1;
   bit wr_act   = 0;
   bit wr_ok    = 0;
   int wr_a     = 0;
   int wr_k     = 0;

   task automatic model_clear();
      exp_c2.delete();
      exp_d2.delete();
      acc_edge = -1;
      ret_edge = -1;
      wr_act   = 0;
   endtask

   always @(negedge RESET) model_clear();

   initial begin
      forever begin
         @(posedge CLK);
         if (!RESET) begin
            model_clear();
         end else begin
            cyc++;
            if (wr_act) begin
               if (wr_ok) mm[wr_a][wr_k] = D2_IN;
               wr_k++;
               if (wr_k == BEATS) wr_act = 0;
            end else if (cyc > ret_edge && C2_IN[1]) begin
               bit ok;
               int a;
               a   = int'(A2_IN);
               ok  = (a < 8);
               acc_edge = cyc;
               if (C2_IN[0]) begin
                  if (ok) mm[a][0] = D2_IN;
                  wr_act = 1; wr_ok = ok; wr_a = a; wr_k = 1;
                  exp_c2[cyc + BEATS + LAT] = ok ? 2'd1 : 2'd2;
                  exp_d2[cyc + BEATS + LAT] = 16'h0;
                  ret_edge = cyc + BEATS + LAT + 1;
               end else begin
                  for (int k = 0; k < BEATS; k++) begin
                     exp_c2[cyc + LAT + 1 + k] = ok ? 2'd1 : 2'd2;
                     exp_d2[cyc + LAT + 1 + k] = ok ? mm[a][k] : 16'h0;
                  end
                  ret_edge = cyc + LAT + BEATS + 1;
               end
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge CLK);
         begin
            logic [1:0]  ec;
            logic [15:0] ed;
            logic        eb;
            ec = exp_c2.exists(cyc) ? exp_c2[cyc] : 2'd0;
            ed = exp_d2.exists(cyc) ? exp_d2[cyc] : 16'h0;
            eb = (acc_edge >= 0) && (cyc >= acc_edge) && (cyc < ret_edge);
            chk($sformatf("c2@%0d", cyc), 32'(C2_OUT), 32'(ec));
            chk($sformatf("d2@%0d", cyc), 32'(D2_OUT), 32'(ed));
            chk($sformatf("busy@%0d", cyc), 32'(BUSY), 32'(eb));
         end
      end
   end

   task automatic wr_line(input logic [3:0] a, input logic [15:0] base,
                          input int nb);
      C2_IN = 2'd3; A2_IN = a; D2_IN = base;
      @(negedge CLK);
      C2_IN = 2'd0;
      for (int k = 1; k < nb; k++) begin
         D2_IN = base + 16'(k);
         @(negedge CLK);
      end
   endtask

   task automatic rd_line(input logic [3:0] a);
      C2_IN = 2'd2; A2_IN = a;
      @(negedge CLK);
      C2_IN = 2'd0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (BUSY === 1'b1 && n < 100) begin
         @(negedge CLK);
         n++;
      end
      if (n >= 100) chk("idle_timeout", 32'(BUSY), 32'd0);
   endtask

   task automatic rd_chk(input logic [3:0] a, input logic [1:0] rc,
                         input logic [15:0] d0, input logic [15:0] d7);
      rd_line(a);
      repeat (4) @(negedge CLK);
      chk("rd_pre_lat", 32'(C2_OUT), 32'd0);
      @(negedge CLK);
      chk("rd_first_c2", 32'(C2_OUT), 32'(rc));
      chk("rd_first_d", 32'(D2_OUT), 32'(d0));
      repeat (7) @(negedge CLK);
      chk("rd_last_d", 32'(D2_OUT), 32'(d7));
      @(negedge CLK);
      chk("rd_busy_drop", 32'(BUSY), 32'd0);
   endtask

   task automatic wr_chk(input logic [3:0] a, input logic [15:0] base,
                         input logic [1:0] rc);
      wr_line(a, base, BEATS);
      repeat (4) @(negedge CLK);
      chk("wr_pre_rsp", 32'(C2_OUT), 32'd0);
      @(negedge CLK);
      chk("wr_rsp_c2", 32'(C2_OUT), 32'(rc));
      chk("wr_rsp_d", 32'(D2_OUT), 32'd0);
      @(negedge CLK);
      chk("wr_busy_drop", 32'(BUSY), 32'd0);
   endtask

   initial begin
      int cnt;
      RESET = 1'b0; C2_IN = 2'd0; A2_IN = '0; D2_IN = '0;
      repeat (3) @(negedge CLK);
      RESET = 1'b1;
      chk("rst_c2", 32'(C2_OUT), 32'd0);
      chk("rst_d2", 32'(D2_OUT), 32'd0);
      chk("rst_busy", 32'(BUSY), 32'd0);

      for (int l = 0; l < 8; l++) begin
         wr_line(4'(l), 16'(l * 16'h1000), BEATS);
         wait_idle();
      end

      // Write then back-to-back read in the first BUSY-low cycle.
      wr_chk(4'd3, 16'h0100, 2'd1);
      rd_chk(4'd3, 2'd1, 16'h0100, 16'h0107);

      // A second read while busy is dropped.
      rd_line(4'd0);
      repeat (2) @(negedge CLK);
      rd_line(4'd5);
      cnt = 0;
      repeat (30) begin
         @(negedge CLK);
         if (C2_OUT == 2'd1) cnt++;
      end
      chk("one_burst", 32'(cnt), 32'd8);
      wait_idle();

      wr_chk(4'd9, 16'hAAA0, 2'd2);
      rd_chk(4'd9, 2'd2, 16'h0000, 16'h0000);
      rd_chk(4'd1, 2'd1, 16'h1000, 16'h1007);

      // Asynchronous reset in the middle of a read burst.
      rd_line(4'd4);
      repeat (6) @(negedge CLK);
      #2 RESET = 1'b0;
      #1;
      chk("arst_c2", 32'(C2_OUT), 32'd0);
      chk("arst_d2", 32'(D2_OUT), 32'd0);
      chk("arst_busy", 32'(BUSY), 32'd0);
      @(negedge CLK);
      RESET = 1'b1;
      @(negedge CLK);

      // Reset after three write beats leaves a partial line.
      wr_line(4'd2, 16'hB000, 3);
      #2 RESET = 1'b0;
      #1 chk("wrst_busy", 32'(BUSY), 32'd0);
      @(negedge CLK);
      RESET = 1'b1;
      @(negedge CLK);
      rd_chk(4'd2, 2'd1, 16'hB000, 16'h2007);

      repeat (3000) begin
         int r;
         r = int'($urandom_range(0, 9));
         C2_IN = (r < 5) ? 2'd0 : (r < 6) ? 2'd1 : (r < 8) ? 2'd2 : 2'd3;
         A2_IN = 4'($urandom_range(0, 15));
         D2_IN = 16'($urandom);
         @(negedge CLK);
      end
      C2_IN = 2'd0;
      repeat (30) @(negedge CLK);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
